// File: rtl/wb_stage_if.sv
// Writeback stage bus: retiring-instruction handshake, load return
// path and register-file write port, grouped for wb_stage.
interface wb_stage_if #(
    parameter int REG_LEN = 32,
    parameter int RADDR_W = 5
);
    localparam int OFF_W = $clog2(REG_LEN / 8);

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         rd_sel;
    logic [RADDR_W-1:0] rd_idx;
    logic [REG_LEN-1:0] imm;
    logic [REG_LEN-1:0] pc;
    logic [REG_LEN-1:0] alu_out;
    logic [2:0]         ld_fmt;
    logic [OFF_W-1:0]   ld_off;
    logic               mem_ack;
    logic [REG_LEN-1:0] rd_mem;
    logic               rd_we;
    logic [RADDR_W-1:0] rd_waddr;
    logic [REG_LEN-1:0] rd_d;
    logic               mem_err;

    modport master (
        output in_valid, rd_sel, rd_idx, imm, pc, alu_out,
        output ld_fmt, ld_off, mem_ack, rd_mem,
        input  in_ready, rd_we, rd_waddr, rd_d, mem_err
    );

    modport slave (
        input  in_valid, rd_sel, rd_idx, imm, pc, alu_out,
        input  ld_fmt, ld_off, mem_ack, rd_mem,
        output in_ready, rd_we, rd_waddr, rd_d, mem_err
    );
endinterface

// File: rtl/wb_stage.sv
// Register-file writeback stage: selects rd data from IMM, PC+step,
// ALU or an extended load, waiting a bounded time for memory data.
module wb_stage #(
    parameter int REG_LEN     = 32,
    parameter int RADDR_W     = 5,
    parameter int PC_STEP     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input logic      clk,
    input logic      rst,
    wb_stage_if.slave bus
);
    localparam int OFF_W = $clog2(REG_LEN / 8);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] RD_IMM  = 2'd0;
    localparam logic [1:0] RD_PCP4 = 2'd1;
    localparam logic [1:0] RD_ALU  = 2'd2;
    localparam logic [1:0] RD_MEM  = 2'd3;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [RADDR_W-1:0] idx_q, idx_n;
    logic [2:0]         fmt_q, fmt_n;
    logic [OFF_W-1:0]   off_q, off_n;
    logic               we_q, we_n;
    logic [RADDR_W-1:0] waddr_q, waddr_n;
    logic [REG_LEN-1:0] d_q, d_n;
    logic               err_q, err_n;
    logic [REG_LEN-1:0] sel_d;

    // Load lanes are picked by shifting the byte offset down to bit 0;
    // halves at the top byte simply see zeros above the word.
    function automatic logic [REG_LEN-1:0] extend(
        input logic [REG_LEN-1:0] d,
        input logic [2:0]         fmt,
        input logic [OFF_W-1:0]   off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {off, 3'b000});
        h = 16'(d >> {off, 3'b000});
        case (fmt)
            3'b000:  return REG_LEN'($signed(b));
            3'b001:  return REG_LEN'($signed(h));
            3'b100:  return REG_LEN'(b);
            3'b101:  return REG_LEN'(h);
            default: return REG_LEN'($signed(d[31:0]));
        endcase
    endfunction

    assign bus.in_ready = (state == IDLE);
    assign bus.rd_we    = we_q;
    assign bus.rd_waddr = waddr_q;
    assign bus.rd_d     = d_q;
    assign bus.mem_err  = err_q;

    // Non-load rd data source
    always_comb begin
        sel_d = bus.alu_out;
        unique case (bus.rd_sel)
            RD_IMM:  sel_d = bus.imm;
            RD_PCP4: sel_d = bus.pc + REG_LEN'(PC_STEP);
            default: sel_d = bus.alu_out;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx_q;
        fmt_n   = fmt_q;
        off_n   = off_q;
        we_n    = 1'b0;
        waddr_n = waddr_q;
        d_n     = d_q;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.rd_sel == RD_MEM) begin
                        state_n = WAIT_MEM;
                        cnt_n   = '0;
                        idx_n   = bus.rd_idx;
                        fmt_n   = bus.ld_fmt;
                        off_n   = bus.ld_off;
                    end else if (bus.rd_idx != '0) begin
                        we_n    = 1'b1;
                        waddr_n = bus.rd_idx;
                        d_n     = sel_d;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_ack) begin
                    state_n = IDLE;
                    if (idx_q != '0) begin
                        we_n    = 1'b1;
                        waddr_n = idx_q;
                        d_n     = extend(bus.rd_mem, fmt_q, off_q);
                    end
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            fmt_q   <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx_q   <= idx_n;
            fmt_q   <= fmt_n;
            off_q   <= off_n;
            we_q    <= we_n;
            waddr_q <= waddr_n;
            d_q     <= d_n;
            err_q   <= err_n;
        end
    end
endmodule
